phys_reg_freelist: RTL and testbench

PHYS_REG_FREELIST -- requirements
Module: phys_reg_freelist

---
 rtl/ooo_pkg.sv | 26 ++
 rtl/freelist_ram.sv | 37 +++
 rtl/phys_reg_freelist.sv | 171 +++++++++++++++++
 tb/tb_phys_reg_freelist.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// ooo_pkg: shared sizes and types for the out-of-order rename path.
// Holds the physical tag type and free-list pointer and count widths.
package ooo_pkg;

    localparam int NUM_PHYS   = 64;
    localparam int NUM_ARCH   = 32;
    localparam int FL_DEPTH   = 32;
    localparam int PHYS_TAG_W = 6;
    localparam int FL_PTR_W   = 5;
    localparam int FL_CNT_W   = 6;

    typedef logic [PHYS_TAG_W-1:0] phys_tag_t;
    typedef logic [FL_PTR_W-1:0]   fl_ptr_t;
    typedef logic [FL_CNT_W-1:0]   fl_cnt_t;

    typedef struct packed {
        logic      en;
        fl_ptr_t   addr;
        phys_tag_t data;
    } fl_wr_t;

    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/freelist_ram.sv
// freelist_ram: 32x6 tag storage, two async reads, two sync writes.
// Reset reloads the non-architectural tags p32..p63 in order.
module freelist_ram
    import ooo_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  fl_ptr_t   rd_addr0,
    input  fl_ptr_t   rd_addr1,
    output phys_tag_t rd_data0,
    output phys_tag_t rd_data1,
    input  fl_wr_t    wr0,
    input  fl_wr_t    wr1
);

    phys_tag_t mem [FL_DEPTH];

    // Storage: reset seeds entry i with tag 32+i, else apply both writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem[i] <= phys_tag_t'(NUM_ARCH + i);
            end
        end else begin
            if (wr0.en) begin
                mem[wr0.addr] <= wr0.data;
            end
            if (wr1.en) begin
                mem[wr1.addr] <= wr1.data;
            end
        end
    end

    assign rd_data0 = mem[rd_addr0];
    assign rd_data1 = mem[rd_addr1];

endmodule

// File: rtl/phys_reg_freelist.sv
// phys_reg_freelist: 2-wide rename free list of physical tags.
// Define FREELIST_BYPASS_EN to let same-cycle releases cover a shortfall.
module phys_reg_freelist
    import ooo_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] alloc_req,
    output logic       alloc_gnt,
    output phys_tag_t  alloc_tag0,
    output phys_tag_t  alloc_tag1,
    input  logic [1:0] free_valid,
    input  phys_tag_t  free_tag0,
    input  phys_tag_t  free_tag1,
    output logic [5:0] free_count,
    output logic       stall,
    output logic       overflow_err
);

    fl_ptr_t   head_q;
    fl_ptr_t   tail_q;
    fl_cnt_t   count_q;
    logic      ovf_q;

    phys_tag_t rd_data0;
    phys_tag_t rd_data1;
    fl_wr_t    wr0;
    fl_wr_t    wr1;

    logic [1:0] req_n;
    logic [1:0] fifo_n;
    logic [1:0] nbyp;
    logic [1:0] pops;
    logic [1:0] pushes;
    logic       rel0;
    logic       rel1;
    logic       gnt;
    logic       byp_mode;
    logic       use0;
    logic       use1;
    logic       cand0;
    logic       cand1;
    logic       push0;
    logic       push1;
    logic       drop0;
    logic       drop1;
    logic [6:0] room;
    phys_tag_t  byp0;
    phys_tag_t  tag0_d;
    phys_tag_t  tag1_d;
`ifdef FREELIST_BYPASS_EN
    logic [1:0] rel_n;
`endif

    // Tag for the k-th requesting slot: FIFO entries first, then releases.
    function automatic phys_tag_t pick(
        input logic       rank,
        input logic [1:0] nf,
        input phys_tag_t  f0,
        input phys_tag_t  f1,
        input phys_tag_t  b0,
        input phys_tag_t  b1
    );
        phys_tag_t t;
        t = '0;
        unique case (1'b1)
            (!rank && nf != 2'd0): t = f0;
            (!rank && nf == 2'd0): t = b0;
            ( rank && nf == 2'd2): t = f1;
            ( rank && nf == 2'd1): t = b0;
            ( rank && nf == 2'd0): t = b1;
            default:               t = '0;
        endcase
        return t;
    endfunction

    freelist_ram u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr0 (head_q),
        .rd_addr1 (head_q + 5'd1),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .wr0      (wr0),
        .wr1      (wr1)
    );

    // Grant, bypass selection and release push/drop decisions.
    always_comb begin
        req_n    = pop2(alloc_req);
        rel0     = free_valid[0] && (free_tag0 != '0);
        rel1     = free_valid[1] && (free_tag1 != '0);
        byp_mode = 1'b0;
        gnt      = 1'b0;
`ifdef FREELIST_BYPASS_EN
        rel_n = pop2({rel1, rel0});
        if (count_q < {4'd0, req_n}) begin
            byp_mode = 1'b1;
            gnt = ({1'b0, count_q[1:0]} + {1'b0, rel_n})
                  >= {1'b0, req_n};
        end else begin
            gnt = 1'b1;
        end
`else
        gnt = count_q >= {4'd0, req_n};
`endif
        gnt    = gnt && rst_n;
        fifo_n = byp_mode ? count_q[1:0] : req_n;
        pops   = gnt ? fifo_n : 2'd0;
        nbyp   = (gnt && byp_mode) ? (req_n - fifo_n) : 2'd0;
        use0   = rel0 && (nbyp != 2'd0);
        use1   = rel1 && ((nbyp == 2'd2) ||
                          ((nbyp == 2'd1) && !rel0));
        byp0   = rel0 ? free_tag0 : free_tag1;

        tag0_d = '0;
        tag1_d = '0;
        if (gnt && alloc_req[0]) begin
            tag0_d = pick(1'b0, fifo_n, rd_data0, rd_data1,
                          byp0, free_tag1);
        end
        if (gnt && alloc_req[1]) begin
            tag1_d = pick(alloc_req[0], fifo_n, rd_data0, rd_data1,
                          byp0, free_tag1);
        end

        cand0  = rel0 && !use0;
        cand1  = rel1 && !use1;
        room   = 7'd32 - {1'b0, count_q} + {5'd0, pops};
        push0  = cand0 && (room != 7'd0);
        push1  = cand1 && (room > {6'd0, push0});
        drop0  = cand0 && !push0;
        drop1  = cand1 && !push1;
        pushes = pop2({push1, push0});

        wr0      = '0;
        wr1      = '0;
        wr0.en   = push0 || push1;
        wr0.addr = tail_q;
        wr0.data = push0 ? free_tag0 : free_tag1;
        wr1.en   = push0 && push1;
        wr1.addr = tail_q + 5'd1;
        wr1.data = free_tag1;
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= fl_cnt_t'(FL_DEPTH);
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_q + fl_ptr_t'(pops);
            tail_q  <= tail_q + fl_ptr_t'(pushes);
            count_q <= count_q - fl_cnt_t'(pops)
                       + fl_cnt_t'(pushes);
            if (drop0 || drop1) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign alloc_gnt    = gnt;
    assign alloc_tag0   = tag0_d;
    assign alloc_tag1   = tag1_d;
    assign stall        = rst_n && (alloc_req != 2'b00) && !gnt;
    assign free_count   = count_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_phys_reg_freelist.sv
// tb_phys_reg_freelist: random and directed traffic against a queue model.
// Expectations go to a scoreboard; a negedge monitor pops and compares.
module tb_phys_reg_freelist;
    import ooo_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [1:0] alloc_req;
    logic       alloc_gnt;
    phys_tag_t  alloc_tag0;
    phys_tag_t  alloc_tag1;
    logic [1:0] free_valid;
    phys_tag_t  free_tag0;
    phys_tag_t  free_tag1;
    logic [5:0] free_count;
    logic       stall;
    logic       overflow_err;

    phys_reg_freelist dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_tag0   (alloc_tag0),
        .alloc_tag1   (alloc_tag1),
        .free_valid   (free_valid),
        .free_tag0    (free_tag0),
        .free_tag1    (free_tag1),
        .free_count   (free_count),
        .stall        (stall),
        .overflow_err (overflow_err)
    );

    typedef struct {
        bit        gnt;
        phys_tag_t t0;
        phys_tag_t t1;
        bit        stl;
        int        cnt;
        bit        ovf;
    } exp_t;

    exp_t      sb[$];
    exp_t      me;
    phys_tag_t fl[$];
    bit        ovf_m;
    int        tests;
    int        fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        fl.delete();
        for (int i = 0; i < 32; i++) begin
            fl.push_back(phys_tag_t'(32 + i));
        end
        ovf_m = 1'b0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the edge, queue the expectation.
    task automatic step(input bit rst, input logic [1:0] req,
                        input logic [1:0] fv, input phys_tag_t a,
                        input phys_tag_t b);
        exp_t      e;
        phys_tag_t rel[$];
        phys_tag_t g[$];
        int        n;
        int        avail;
        int        nf;
        bit        ok;
        @(posedge clk);
        #1;
        rst_n      = !rst;
        alloc_req  = req;
        free_valid = fv;
        free_tag0  = a;
        free_tag1  = b;
        e.gnt = 1'b0;
        e.t0  = '0;
        e.t1  = '0;
        e.stl = 1'b0;
        e.cnt = 32;
        e.ovf = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            n = int'(req[0]) + int'(req[1]);
            if (fv[0] && a != 0) rel.push_back(a);
            if (fv[1] && b != 0) rel.push_back(b);
            avail = fl.size();
            ok = avail >= n;
`ifdef FREELIST_BYPASS_EN
            if (!ok) ok = (avail + rel.size()) >= n;
`endif
            e.cnt = avail;
            e.ovf = ovf_m;
            e.gnt = ok;
            e.stl = (n != 0) && !ok;
            if (ok) begin
                nf = (n < avail) ? n : avail;
                for (int k = 0; k < nf; k++) g.push_back(fl.pop_front());
                for (int k = nf; k < n; k++) g.push_back(rel.pop_front());
                if (req[0]) e.t0 = g.pop_front();
                if (req[1]) e.t1 = g.pop_front();
            end
            foreach (rel[i]) begin
                if (fl.size() < 32) fl.push_back(rel[i]);
                else ovf_m = 1'b1;
            end
        end
        sb.push_back(e);
    endtask

    // Monitor: compare every presented cycle against the scoreboard head.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            chk("alloc_gnt", int'(alloc_gnt), int'(me.gnt));
            chk("alloc_tag0", int'(alloc_tag0), int'(me.t0));
            chk("alloc_tag1", int'(alloc_tag1), int'(me.t1));
            chk("stall", int'(stall), int'(me.stl));
            chk("free_count", int'(free_count), me.cnt);
            chk("overflow_err", int'(overflow_err), int'(me.ovf));
        end
    end

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        alloc_req  = '0;
        free_valid = '0;
        free_tag0  = '0;
        free_tag1  = '0;
        model_reset();

        repeat (3) step(1, 2'b00, 2'b00, 0, 0);
        repeat (16) step(0, 2'b11, 2'b00, 0, 0);
        step(0, 2'b01, 2'b00, 0, 0);
        step(0, 2'b10, 2'b00, 0, 0);
        step(0, 2'b00, 2'b01, 40, 0);
        step(0, 2'b11, 2'b00, 0, 0);
        step(0, 2'b11, 2'b01, 40, 0);
        step(0, 2'b10, 2'b10, 0, 41);
        step(0, 2'b00, 2'b00, 0, 0);

        step(1, 2'b00, 2'b00, 0, 0);
        step(0, 2'b00, 2'b01, 45, 0);
        repeat (3) step(0, 2'b00, 2'b00, 0, 0);

        step(1, 2'b00, 2'b00, 0, 0);
        repeat (40) step(0, 2'b11, 2'b11, 50, 51);

        step(0, 2'b11, 2'b00, 0, 0);
        step(0, 2'b00, 2'b01, 0, 0);
        step(0, 2'b00, 2'b11, 0, 7);
        step(0, 2'b01, 2'b00, 0, 0);
        step(1, 2'b11, 2'b11, 9, 10);
        step(0, 2'b11, 2'b00, 0, 0);

        for (int c = 0; c < 800; c++) begin
            int ar;
            int fr;
            ar = $urandom_range(0, 99);
            fr = $urandom_range(0, 99);
            step(($urandom_range(0, 99) == 0),
                 2'($urandom_range(0, 3) & (ar < 60 ? 3 : 1)),
                 2'($urandom_range(0, 3) & (fr < 50 ? 3 : 0)),
                 phys_tag_t'($urandom_range(0, 63)),
                 phys_tag_t'($urandom_range(0, 63)));
        end

        for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
        if (sb.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d left, expected 0", sb.size());
        end
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
